// File: rtl/kernel_dense_acc_pkg.sv
// Shared constants and FSM state encoding for the dense accumulate kernel.
package kernel_dense_acc_pkg;

    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

    localparam int unsigned DENSE_BIT_DATA = 8;
    localparam int unsigned DENSE_KSIZE    = 4;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/kernel_dense_acc_sat_add_lane.sv
// One signed saturating accumulator lane with a sticky overflow flag.
module sat_add_lane
    import kernel_dense_acc_pkg::*;
#(
    parameter int unsigned BIT_ACC = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [BIT_ACC-1:0] add_i,
    output logic [BIT_ACC-1:0] acc_o,
    output logic               sat_o
);

    localparam logic [BIT_ACC-1:0] ACC_MAX = {1'b0, {(BIT_ACC-1){1'b1}}};
    localparam logic [BIT_ACC-1:0] ACC_MIN = {1'b1, {(BIT_ACC-1){1'b0}}};

    logic [BIT_ACC-1:0] acc_q, acc_d, sum;
    logic [BIT_ACC:0]   full;
    logic               sat_q, sat_d, ovf;

    always_comb begin
        // One guard bit: overflow shows up as disagreement between the top two bits.
        full  = {acc_q[BIT_ACC-1], acc_q} + {add_i[BIT_ACC-1], add_i};
        ovf   = (full[BIT_ACC] != full[BIT_ACC-1]);
        sum   = ovf ? (full[BIT_ACC] ? ACC_MIN : ACC_MAX) : full[BIT_ACC-1:0];
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_i) begin
            acc_d = '0;
            sat_d = OFF;
        end else if (en_i) begin
            acc_d = sum;
            sat_d = sat_q | ovf;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
            sat_q <= OFF;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/kernel_dense_acc.sv
// Dense-layer kernel: per beat, x times N_LANE weights, accumulated over up to N_IN beats.
module kernel_dense_acc
    import kernel_dense_acc_pkg::*;
#(
    parameter int unsigned BIT_DATA = DENSE_BIT_DATA,
    parameter int unsigned N_LANE   = DENSE_KSIZE,
    parameter int unsigned N_IN     = 16,
    parameter int unsigned BIT_ACC  = 2*BIT_DATA + $clog2(N_IN),
    parameter bit          RELU     = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [BIT_DATA-1:0]        x,
    input  logic [BIT_DATA*N_LANE-1:0] w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_ACC*N_LANE-1:0]  y,
    output logic                       sat
);

    localparam int unsigned        BIT_CNT  = $clog2(N_IN + 1);
    localparam logic [BIT_CNT-1:0] CNT_LAST = BIT_CNT'(N_IN - 1);

    state_t                       state_q, state_d;
    logic [BIT_CNT-1:0]           cnt_q, cnt_d;
    logic signed [2*BIT_DATA-1:0] p_q [N_LANE];
    logic signed [2*BIT_DATA-1:0] p_d [N_LANE];
    logic                         p_valid_q, p_valid_d;
    logic                         out_valid_q, out_valid_d;
    logic [BIT_ACC*N_LANE-1:0]    y_q, y_d;
    logic                         sat_q, sat_d;

    logic signed [BIT_DATA-1:0]   x_s;
    logic signed [BIT_DATA-1:0]   w_s  [N_LANE];
    logic signed [2*BIT_DATA-1:0] prod [N_LANE];
    logic [BIT_ACC-1:0]           p_ext    [N_LANE];
    logic [BIT_ACC-1:0]           lane_acc [N_LANE];
    logic [N_LANE-1:0]            lane_sat;
    logic                         acc_clr;

    always_comb begin
        x_s = x;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            w_s[i]   = w[i*BIT_DATA +: BIT_DATA];
            prod[i]  = x_s * w_s[i];
            p_ext[i] = BIT_ACC'(p_q[i]);
        end
    end

    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        sat_add_lane #(
            .BIT_ACC (BIT_ACC)
        ) u_lane (
            .clk_i  (clock),
            .rst_ni (reset),
            .en_i   (p_valid_q),
            .clr_i  (acc_clr),
            .add_i  (p_ext[g]),
            .acc_o  (lane_acc[g]),
            .sat_o  (lane_sat[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        p_valid_d   = OFF;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        sat_d       = sat_q;
        acc_clr     = OFF;
        in_ready    = OFF;
        unique case (state_q)
            ACC: begin
                in_ready = ON;
                if (in_valid) begin
                    p_d       = prod;
                    p_valid_d = ON;
                    cnt_d     = cnt_q + BIT_CNT'(1);
                    if (in_last || (cnt_q == CNT_LAST)) state_d = FLUSH;
                end
            end
            FLUSH: state_d = OUT;
            OUT: begin
                // First OUT cycle captures the settled accumulators; y/sat then hold until out_ready.
                if (!out_valid_q) begin
                    for (int unsigned i = 0; i < N_LANE; i++) begin
                        y_d[i*BIT_ACC +: BIT_ACC] =
                            (RELU && lane_acc[i][BIT_ACC-1]) ? '0 : lane_acc[i];
                    end
                    sat_d       = |lane_sat;
                    out_valid_d = ON;
                end else if (out_ready) begin
                    out_valid_d = OFF;
                    sat_d       = OFF;
                    acc_clr     = ON;
                    cnt_d       = '0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            p_valid_q   <= OFF;
            out_valid_q <= OFF;
            y_q         <= '0;
            sat_q       <= OFF;
            for (int unsigned i = 0; i < N_LANE; i++) p_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_kernel_dense_acc.sv
// Self-checking bench: three kernel configurations checked against a saturating dot-product model.
module tb_kernel_dense_acc;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  x = '0;
    logic [31:0] w = '0;
    logic [2:0]  in_ready_v, out_valid_v, sat_v;
    logic [79:0] y_a, y_b;
    logic [63:0] y_c;

    int errors = 0;
    int checks = 0;
    int mx [32];
    int mw [32][4];
    int exp_y [4];
    bit exp_sat;

    always #5 clock = ~clock;

    kernel_dense_acc u_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .y(y_a), .sat(sat_v[0]));

    kernel_dense_acc #(.RELU(1'b1)) u_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .y(y_b), .sat(sat_v[1]));

    kernel_dense_acc #(.N_IN(4), .BIT_ACC(16)) u_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .y(y_c), .sat(sat_v[2]));

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int lane(input int s, input int i);
        logic [19:0] a;
        logic [15:0] c;
        if (s == 0) begin
            a = y_a[i*20 +: 20];
            return int'($signed(a));
        end else if (s == 1) begin
            a = y_b[i*20 +: 20];
            return int'($signed(a));
        end
        c = y_c[i*16 +: 16];
        return int'($signed(c));
    endfunction

    // Dot product of the first n beats per lane, clamped after each add.
    task automatic model(input int n, input bit relu, input int bacc);
        longint amax, amin, acc;
        amax = (longint'(1) <<< (bacc - 1)) - 1;
        amin = -(longint'(1) <<< (bacc - 1));
        exp_sat = 1'b0;
        for (int l = 0; l < 4; l++) begin
            acc = 0;
            for (int b = 0; b < n; b++) begin
                acc = acc + longint'(mx[b]) * longint'(mw[b][l]);
                if (acc > amax) begin acc = amax; exp_sat = 1'b1; end
                else if (acc < amin) begin acc = amin; exp_sat = 1'b1; end
            end
            exp_y[l] = (relu && acc < 0) ? 0 : int'(acc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic set_beat(input int b, input bit last);
        int xv, wv;
        xv = mx[b];
        x = xv[7:0];
        for (int l = 0; l < 4; l++) begin
            wv = mw[b][l];
            w[l*8 +: 8] = wv[7:0];
        end
        in_last  = last;
        in_valid = 1'b1;
    endtask

    // Presents beat b and returns just after the edge that accepts it.
    task automatic drive_beat(input int s, input int b, input bit last);
        int n;
        set_beat(b, last);
        n = 0;
        while (in_ready_v[s] !== 1'b1 && n < 100) begin step(); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut=%0d beat=%0d: in_ready never rose", s, b);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int s);
        int n;
        n = 0;
        while (out_valid_v[s] !== 1'b1 && n < 100) begin step(); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL out_timeout dut=%0d: out_valid never rose", s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (in_ready_v[s] !== 1'b1) begin errors++;
                $display("FAIL reset_in_ready dut=%0d got=%b want=1", s, in_ready_v[s]); end
            checks++;
            if (out_valid_v[s] !== 1'b0) begin errors++;
                $display("FAIL reset_out_valid dut=%0d got=%b want=0", s, out_valid_v[s]); end
            checks++;
            if (sat_v[s] !== 1'b0) begin errors++;
                $display("FAIL reset_sat dut=%0d got=%b want=0", s, sat_v[s]); end
        end
        checks++;
        if (y_a !== '0 || y_b !== '0 || y_c !== '0) begin errors++;
            $display("FAIL reset_y got=%h/%h/%h want=0", y_a, y_b, y_c); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        mx[0] = 2; mx[1] = 3; mx[2] = -1;
        for (int b = 0; b < 3; b++) for (int l = 0; l < 4; l++) mw[b][l] = 4;
        model(3, 1'b0, 20);
        drive_beat(0, 0, 1'b0);
        drive_beat(0, 1, 1'b0);
        drive_beat(0, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready_v[0] !== 1'b0) begin errors++;
                $display("FAIL basic_in_ready_low cyc=%0d got=%b want=0", k, in_ready_v[0]); end
            checks++;
            if (out_valid_v[0] !== (k == 2)) begin errors++;
                $display("FAIL basic_latency cyc=%0d out_valid got=%b want=%0d", k, out_valid_v[0], k == 2); end
            if (k < 2) step();
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== exp_y[l] || exp_y[l] != 16) begin errors++;
                $display("FAIL basic_y lane=%0d got=%0d want=16", l, lane(0, l)); end
        end
        checks++;
        if (sat_v[0] !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b want=0", sat_v[0]); end
        step();
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin errors++;
            $display("FAIL basic_return in_ready=%b out_valid=%b want 1/0", in_ready_v[0], out_valid_v[0]); end
    endtask

    task automatic test_lane_weights();
        int want_a [4];
        int want_b [4];
        want_a = '{-5, 10, -15, 20};
        want_b = '{0, 10, 0, 20};
        do_reset();
        out_ready = 1'b1;
        mx[0] = 5; mw[0] = '{-1, 2, -3, 4};
        drive_beat(0, 0, 1'b1);
        wait_out(0);
        checks++;
        if (out_valid_v[1] !== 1'b1) begin errors++;
            $display("FAIL lanes_relu_valid got=%b want=1", out_valid_v[1]); end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== want_a[l]) begin errors++;
                $display("FAIL lanes_norelu lane=%0d got=%0d want=%0d", l, lane(0, l), want_a[l]); end
            checks++;
            if (lane(1, l) !== want_b[l]) begin errors++;
                $display("FAIL lanes_relu lane=%0d got=%0d want=%0d", l, lane(1, l), want_b[l]); end
        end
        step();
    endtask

    task automatic test_implicit_last();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            mx[b] = 1;
            for (int l = 0; l < 4; l++) mw[b][l] = 1;
            drive_beat(0, b, 1'b0);
        end
        mx[16] = 9;
        for (int l = 0; l < 4; l++) mw[16][l] = 2;
        set_beat(16, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready_v[0] !== 1'b0) begin errors++;
                $display("FAIL implicit_hold cyc=%0d in_ready got=%b want=0", k, in_ready_v[0]); end
            if (k < 2) step();
        end
        checks++;
        if (out_valid_v[0] !== 1'b1) begin errors++;
            $display("FAIL implicit_valid got=%b want=1", out_valid_v[0]); end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== 16) begin errors++;
                $display("FAIL implicit_y lane=%0d got=%0d want=16", l, lane(0, l)); end
        end
        step();
        checks++;
        if (in_ready_v[0] !== 1'b1) begin errors++;
            $display("FAIL implicit_reopen in_ready got=%b want=1", in_ready_v[0]); end
        step();
        in_valid = 1'b0; in_last = 1'b0;
        wait_out(0);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== 18) begin errors++;
                $display("FAIL beat17_y lane=%0d got=%0d want=18", l, lane(0, l)); end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [79:0] held_y;
        logic        held_sat;
        do_reset();
        out_ready = 1'b0;
        mx[0] = -7; mw[0] = '{1, 2, 3, 4};
        drive_beat(0, 0, 1'b1);
        wait_out(0);
        held_y = y_a; held_sat = sat_v[0];
        mx[1] = 3; mw[1] = '{1, 1, 1, 1};
        set_beat(1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (y_a !== held_y || sat_v[0] !== held_sat || out_valid_v[0] !== 1'b1) begin errors++;
                $display("FAIL bp_stable cyc=%0d y=%h sat=%b want y=%h sat=%b valid", k, y_a, sat_v[0], held_y, held_sat); end
            checks++;
            if (in_ready_v[0] !== 1'b0) begin errors++;
                $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, in_ready_v[0]); end
        end
        checks++;
        if (lane(0, 3) !== -28) begin errors++;
            $display("FAIL bp_y lane=3 got=%0d want=-28", lane(0, 3)); end
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0; in_last = 1'b0;
        wait_out(0);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== 3) begin errors++;
                $display("FAIL bp_next_y lane=%0d got=%0d want=3", l, lane(0, l)); end
        end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mx[b] = -128;
            for (int l = 0; l < 4; l++) mw[b][l] = -128;
            drive_beat(2, b, 1'b0);
        end
        wait_out(2);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(2, l) !== 32767) begin errors++;
                $display("FAIL sat_pos lane=%0d got=%0d want=32767", l, lane(2, l)); end
        end
        checks++;
        if (sat_v[2] !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b want=1", sat_v[2]); end
        step();
        for (int b = 0; b < 3; b++) begin
            mx[b] = -128;
            for (int l = 0; l < 4; l++) mw[b][l] = 127;
            drive_beat(2, b, b == 2);
        end
        wait_out(2);
        checks++;
        if (lane(2, 0) !== -32768 || sat_v[2] !== 1'b1) begin errors++;
            $display("FAIL sat_neg got=%0d sat=%b want=-32768 sat=1", lane(2, 0), sat_v[2]); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        mx[0] = 100; mx[1] = -90;
        for (int l = 0; l < 4; l++) begin mw[0][l] = 50; mw[1][l] = 3; end
        drive_beat(0, 0, 1'b0);
        drive_beat(0, 1, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid_v[0] !== 1'b0) begin errors++;
                $display("FAIL midreset_valid cyc=%0d got=%b want=0", k, out_valid_v[0]); end
            step();
        end
        mx[0] = 1;
        for (int l = 0; l < 4; l++) mw[0][l] = 7;
        drive_beat(0, 0, 1'b1);
        wait_out(0);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (lane(0, l) !== 7) begin errors++;
                $display("FAIL midreset_y lane=%0d got=%0d want=7", l, lane(0, l)); end
        end
        step();
    endtask

    task automatic test_random();
        int s, n, nmax, hold;
        bit use_last;
        for (int it = 0; it < 40; it++) begin
            s    = (it % 2 == 0) ? 0 : 2;
            nmax = (s == 0) ? 16 : 4;
            n    = int'($urandom_range(1, nmax));
            use_last = (n < nmax) ? 1'b1 : 1'(($urandom_range(0, 1)));
            for (int b = 0; b < n; b++) begin
                mx[b] = int'($urandom_range(0, 255)) - 128;
                for (int l = 0; l < 4; l++) mw[b][l] = int'($urandom_range(0, 255)) - 128;
            end
            do_reset();
            hold = int'($urandom_range(0, 3));
            out_ready = (hold == 0);
            for (int b = 0; b < n; b++) begin
                drive_beat(s, b, use_last && (b == n - 1));
                repeat ($urandom_range(0, 1)) step();
            end
            wait_out(s);
            repeat (hold) step();
            model(n, 1'b0, (s == 0) ? 20 : 16);
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (lane(s, l) !== exp_y[l]) begin errors++;
                    $display("FAIL rand_y it=%0d dut=%0d n=%0d lane=%0d got=%0d want=%0d", it, s, n, l, lane(s, l), exp_y[l]); end
            end
            checks++;
            if (sat_v[s] !== exp_sat) begin errors++;
                $display("FAIL rand_sat it=%0d dut=%0d got=%b want=%b", it, s, sat_v[s], exp_sat); end
            if (s == 0) begin
                model(n, 1'b1, 20);
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (lane(1, l) !== exp_y[l]) begin errors++;
                        $display("FAIL rand_relu it=%0d lane=%0d got=%0d want=%0d", it, l, lane(1, l), exp_y[l]); end
                end
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lane_weights();
        test_implicit_last();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
